// File: rtl/case_3_mul_share_arb.sv
// -----------------------------------------------------------------------------
// case_3_mul_share_arb
//
// Purpose: shares one signed multiplier (din0 x din1, truncated to DOUT_WIDTH)
// among NUM_REQ requesters. A round-robin arbiter feeds a two-stage pipeline
// (S1 = operand register, S2 = product register). Every result is tagged with
// the index of the requester that issued it.
//
// Ports:
//   ap_clk     in   1                   clock, rising edge
//   ap_rst_n   in   1                   async active-low reset
//   req_valid  in   NUM_REQ             per-requester operand valid
//   req_ready  out  NUM_REQ             per-requester accept (at most one high)
//   req_din0   in   NUM_REQ*DIN0_WIDTH  operand 0, requester i at [i*DIN0_WIDTH +: DIN0_WIDTH]
//   req_din1   in   NUM_REQ*DIN1_WIDTH  operand 1, same packing
//   res_valid  out  1                   result valid (S2 occupied)
//   res_ready  in   1                   downstream accept
//   res_dout   out  DOUT_WIDTH          low bits of the signed product
//   res_id     out  ID_WIDTH            requester index of the result
//   busy       out  1                   S1 or S2 occupied
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid may be withdrawn without a transfer. ready never looks at
// the partner's valid in a way that could loop back: req_ready depends on
// req_valid, but no requester is expected to derive req_valid from req_ready.
// -----------------------------------------------------------------------------
module case_3_mul_share_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DIN0_WIDTH = 3,
  parameter int DIN1_WIDTH = 2,
  parameter int DOUT_WIDTH = 3,
  parameter int ID_WIDTH   = 2
) (
  input  logic                             ap_clk,
  input  logic                             ap_rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]    req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]    req_din1,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [DOUT_WIDTH-1:0]            res_dout,
  output logic [ID_WIDTH-1:0]              res_id,
  output logic                             busy
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

  // Pipeline and arbiter state
  logic [ID_WIDTH-1:0]   rr_ptr_q,   rr_ptr_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [DIN0_WIDTH-1:0] s1_din0_q,  s1_din0_d;
  logic [DIN1_WIDTH-1:0] s1_din1_q,  s1_din1_d;
  logic [ID_WIDTH-1:0]   s1_id_q,    s1_id_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DOUT_WIDTH-1:0] s2_dout_q,  s2_dout_d;
  logic [ID_WIDTH-1:0]   s2_id_q,    s2_id_d;

  logic                  adv;
  logic                  s1_can_accept;
  logic                  grant_found;
  logic [ID_WIDTH-1:0]   grant_id;
  logic [ID_WIDTH-1:0]   cand;
  logic                  fire;
  logic signed [PW-1:0]  prod_full;

  // (base + off) mod NUM_REQ without a divider; base, off < NUM_REQ <= 2**ID_WIDTH
  // so one conditional subtract is enough.
  function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                   input int off);
    logic [ID_WIDTH:0] sum;
    sum = {1'b0, base} + (ID_WIDTH+1)'(off);
    if (sum >= (ID_WIDTH+1)'(NUM_REQ)) begin
      sum = sum - (ID_WIDTH+1)'(NUM_REQ);
    end
    return sum[ID_WIDTH-1:0];
  endfunction

  // S2 moves whenever it is empty or being drained; S1 can take a new operand
  // pair whenever it is empty or moving into S2 this cycle.
  assign adv           = !s2_valid_q | res_ready;
  assign s1_can_accept = !s1_valid_q | adv;

  // Round-robin scan starting at rr_ptr: first requester with valid wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap_add(rr_ptr_q, k);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // ready is masked by reset so nothing is offered while reset is held.
  assign fire = ap_rst_n & grant_found & s1_can_accept;

  always_comb begin
    req_ready = '0;
    if (fire) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  // Operands are sign-extended to full product width before multiplying.
  assign prod_full = PW'($signed(s1_din0_q)) * PW'($signed(s1_din1_q));

  // Next-state logic
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    s1_valid_d = s1_valid_q;
    s1_din0_d  = s1_din0_q;
    s1_din1_d  = s1_din1_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_dout_d  = s2_dout_q;
    s2_id_d    = s2_id_q;

    if (adv) begin
      s2_valid_d = s1_valid_q;
      s2_dout_d  = DOUT_WIDTH'(prod_full);  // silent wrap to the low bits
      s2_id_d    = s1_id_q;
      s1_valid_d = 1'b0;
    end

    if (fire) begin
      s1_valid_d = 1'b1;
      s1_din0_d  = req_din0[grant_id*DIN0_WIDTH +: DIN0_WIDTH];
      s1_din1_d  = req_din1[grant_id*DIN1_WIDTH +: DIN1_WIDTH];
      s1_id_d    = grant_id;
      rr_ptr_d   = wrap_add(grant_id, 1);
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr_q   <= '0;
      s1_valid_q <= 1'b0;
      s1_din0_q  <= '0;
      s1_din1_q  <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_dout_q  <= '0;
      s2_id_q    <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      s1_valid_q <= s1_valid_d;
      s1_din0_q  <= s1_din0_d;
      s1_din1_q  <= s1_din1_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_dout_q  <= s2_dout_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign res_valid = s2_valid_q;
  assign res_dout  = s2_dout_q;
  assign res_id    = s2_id_q;
  assign busy      = s1_valid_q | s2_valid_q;

endmodule
